// File: rtl/fmul_booth_seq_if.sv
// Request/result handshake bundle for the sequential radix-4 Booth multiplier.
interface fmul_booth_seq_if #(
    parameter int PL_N = 24
);
    logic              iREQ_VALID;
    logic              oREQ_BUSY;
    logic [PL_N-1:0]   iREQ_DATA0;
    logic [PL_N-1:0]   iREQ_DATA1;
    logic              oOUT_VALID;
    logic              iOUT_BUSY;
    logic [2*PL_N-1:0] oOUT_DATA;

    modport master (
        output iREQ_VALID, iREQ_DATA0, iREQ_DATA1, iOUT_BUSY,
        input  oREQ_BUSY, oOUT_VALID, oOUT_DATA
    );

    modport slave (
        input  iREQ_VALID, iREQ_DATA0, iREQ_DATA1, iOUT_BUSY,
        output oREQ_BUSY, oOUT_VALID, oOUT_DATA
    );
endinterface

// File: rtl/fmul_booth_seq.sv
// Unsigned PL_N x PL_N multiplier, iterative radix-4 Booth, one group per cycle.
// Optional macro FMUL_BOOTH_SEQ_ZERO_SKIP_EN: a zero operand bypasses CALC.
module fmul_booth_seq #(
    parameter int PL_N = 24
) (
    input  logic            iCLOCK,
    input  logic            inRESET,
    input  logic            iFLUSH,
    fmul_booth_seq_if.slave bus
);
    localparam int ACC_W = 2*PL_N + 4;
    localparam int GRP_N = PL_N/2 + 1;
    localparam int CNT_W = $clog2(GRP_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRP_N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state;
    state_t                   state_n;
    logic                     accept;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  xs;
    logic [PL_N+2:0]          ysh;
    logic [CNT_W-1:0]         cnt;
    logic                     unused_hi;

    function automatic logic signed [ACC_W-1:0] booth_pp(
        input logic [2:0]              grp,
        input logic signed [ACC_W-1:0] x
    );
        logic signed [ACC_W-1:0] pp;
        case (grp)
            3'b001, 3'b010: pp = x;
            3'b011:         pp = x <<< 1;
            3'b100:         pp = -(x <<< 1);
            3'b101, 3'b110: pp = -x;
            default:        pp = '0;
        endcase
        return pp;
    endfunction

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        if (iFLUSH) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iREQ_VALID) begin
                        accept  = 1'b1;
                        state_n = CALC;
`ifdef FMUL_BOOTH_SEQ_ZERO_SKIP_EN
                        if (bus.iREQ_DATA0 == '0 || bus.iREQ_DATA1 == '0)
                            state_n = DONE;
`endif
                    end
                end
                CALC:    if (cnt == CNT_LAST) state_n = DONE;
                DONE:    if (!bus.iOUT_BUSY) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Multiplicand shifts left and multiplier shifts right by one group each cycle,
    // so the current group is always ysh[2:0] (bit 0 starts as the implicit zero).
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            acc <= '0;
            xs  <= '0;
            ysh <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= '0;
            xs  <= {{(ACC_W-PL_N){1'b0}}, bus.iREQ_DATA0};
            ysh <= {2'b00, bus.iREQ_DATA1, 1'b0};
            cnt <= '0;
        end else if (state == CALC && !iFLUSH) begin
            acc <= acc + booth_pp(ysh[2:0], xs);
            xs  <= xs <<< 2;
            ysh <= ysh >> 2;
            cnt <= cnt + 1'b1;
        end
    end

    // The final sum is non-negative and fits in 2*PL_N bits; the guard bits only
    // carry sign during intermediate negative partial sums.
    assign unused_hi     = ^acc[ACC_W-1:2*PL_N];
    assign bus.oREQ_BUSY  = (state != IDLE);
    assign bus.oOUT_VALID = (state == DONE);
    assign bus.oOUT_DATA  = acc[2*PL_N-1:0];
endmodule

// File: tb/tb_fmul_booth_seq.sv
// Directed scoreboard bench for fmul_booth_seq at PL_N=24.
module tb_fmul_booth_seq;
    localparam int PL_N = 24;
    localparam int LAT  = PL_N/2 + 1;
`ifdef FMUL_BOOTH_SEQ_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = LAT;
`endif

    logic iCLOCK;
    logic inRESET;
    logic iFLUSH;

    fmul_booth_seq_if #(.PL_N(PL_N)) bus ();

    fmul_booth_seq #(.PL_N(PL_N)) dut (
        .iCLOCK (iCLOCK),
        .inRESET(inRESET),
        .iFLUSH (iFLUSH),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [2*PL_N-1:0] d;
        int                acc_cyc;
        int                lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;
    always @(posedge iCLOCK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: each new result is matched against the oldest expectation.
    always @(negedge iCLOCK) begin
        if (inRESET) begin
            if (bus.oOUT_VALID && !prev_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 64'(bus.oOUT_DATA), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", 64'(bus.oOUT_DATA), 64'(e.d));
                    chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                end
            end
            prev_valid = bus.oOUT_VALID;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge iCLOCK);
        while (bus.oREQ_BUSY && n < 100) begin
            @(negedge iCLOCK);
            n++;
        end
        if (bus.oREQ_BUSY) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [PL_N-1:0] a, input logic [PL_N-1:0] b,
                         input bit expect_it, input logic [2*PL_N-1:0] prod, input int lat);
        exp_t e;
        wait_idle();
        bus.iREQ_VALID = 1'b1;
        bus.iREQ_DATA0 = a;
        bus.iREQ_DATA1 = b;
        @(posedge iCLOCK);
        #1;
        if (expect_it) begin
            e.d = prod; e.acc_cyc = cyc; e.lat = lat;
            q.push_back(e);
        end
        bus.iREQ_VALID = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.oOUT_VALID && n < 100) begin
            @(negedge iCLOCK);
            n++;
        end
        if (!bus.oOUT_VALID) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int vcnt;
        inRESET        = 1'b0;
        iFLUSH         = 1'b0;
        bus.iREQ_VALID = 1'b0;
        bus.iREQ_DATA0 = '0;
        bus.iREQ_DATA1 = '0;
        bus.iOUT_BUSY  = 1'b0;
        repeat (3) @(negedge iCLOCK);
        chk("rst_busy",  64'(bus.oREQ_BUSY),  64'd0);
        chk("rst_valid", 64'(bus.oOUT_VALID), 64'd0);
        chk("rst_data",  64'(bus.oOUT_DATA),  64'd0);

        // 3*5 accepted on the first edge after reset release
        inRESET        = 1'b1;
        bus.iREQ_VALID = 1'b1;
        bus.iREQ_DATA0 = 24'd3;
        bus.iREQ_DATA1 = 24'd5;
        @(posedge iCLOCK);
        #1;
        begin
            exp_t e;
            e.d = 48'h00000000000F; e.acc_cyc = cyc; e.lat = LAT;
            q.push_back(e);
        end
        bus.iREQ_VALID = 1'b0;
        chk("busy_after_accept", 64'(bus.oREQ_BUSY), 64'd1);
        @(negedge iCLOCK);
        wait_valid();
        @(negedge iCLOCK);
        chk("valid_one_cycle", 64'(bus.oOUT_VALID), 64'd0);

        // All-ones: every negative group plus the extension group; junk requests while busy
        issue(24'hFFFFFF, 24'hFFFFFF, 1, 48'hFFFFFE000001, LAT);
        bus.iREQ_VALID = 1'b1;
        bus.iREQ_DATA0 = 24'h000001;
        bus.iREQ_DATA1 = 24'h000001;
        repeat (3) @(negedge iCLOCK);
        bus.iREQ_VALID = 1'b0;

        issue(24'd3,      24'hAAAAAA, 1, 48'h000001FFFFFE, LAT);
        issue(24'd2,      24'h555555, 1, 48'h000000AAAAAA, LAT);
        issue(24'h800000, 24'h800000, 1, 48'h400000000000, LAT);
        issue(24'hFFFFFF, 24'h800000, 1, 48'h7FFFFF800000, LAT);
        issue(24'h123456, 24'h000010, 1, 48'h000001234560, LAT);
        issue(24'd100,    24'd100,    1, 48'h000000002710, LAT);

        // Downstream stall holds the result
        wait_idle();
        bus.iOUT_BUSY = 1'b1;
        issue(24'h800000, 24'h000002, 1, 48'h000001000000, LAT);
        @(negedge iCLOCK);
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLOCK);
            chk("hold_data",  64'(bus.oOUT_DATA),  64'h000001000000);
            chk("hold_busy",  64'(bus.oREQ_BUSY),  64'd1);
            chk("hold_valid", 64'(bus.oOUT_VALID), 64'd1);
        end
        bus.iOUT_BUSY = 1'b0;
        @(posedge iCLOCK);
        #1;
        chk("release_busy",  64'(bus.oREQ_BUSY),  64'd0);
        chk("release_valid", 64'(bus.oOUT_VALID), 64'd0);

        // Flush in the 6th CALC cycle, then 7*9 straight after
        issue(24'h123456, 24'h654321, 0, '0, LAT);
        repeat (5) @(posedge iCLOCK);
        @(negedge iCLOCK);
        iFLUSH = 1'b1;
        @(negedge iCLOCK);
        iFLUSH = 1'b0;
        chk("flush_busy",  64'(bus.oREQ_BUSY),  64'd0);
        chk("flush_valid", 64'(bus.oOUT_VALID), 64'd0);
        issue(24'd7, 24'd9, 1, 48'h00000000003F, LAT);

        // Asynchronous reset mid-CALC
        issue(24'hFFFFFF, 24'hFFFFFF, 0, '0, LAT);
        repeat (4) @(posedge iCLOCK);
        #3;
        inRESET = 1'b0;
        #1;
        chk("arst_busy",  64'(bus.oREQ_BUSY),  64'd0);
        chk("arst_valid", 64'(bus.oOUT_VALID), 64'd0);
        @(negedge iCLOCK);
        inRESET = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLOCK);
            if (bus.oOUT_VALID) vcnt++;
        end
        chk("no_stale_result", 64'(vcnt), 64'd0);

        // Zero operand
        issue(24'd0, 24'h123456, 1, 48'h0, ZLAT);
        issue(24'hABCDEF, 24'd0, 1, 48'h0, ZLAT);

        wait_idle();
        repeat (3) @(negedge iCLOCK);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fmul_booth_seq.md
FMUL_BOOTH_SEQ -- requirements
Module: fmul_booth_seq

Interface
REQ-001 SHALL have parameter PL_N, default 24: operand width in bits; legal values are even and 4..32.
REQ-002 SHALL have port iCLOCK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port inRESET, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port iFLUSH, input, 1 bit: synchronous abort of any operation in flight.
REQ-005 SHALL have port iREQ_VALID, input, 1 bit: a request is present.
REQ-006 SHALL have port oREQ_BUSY, output, 1 bit: the block cannot accept a request this cycle.
REQ-007 SHALL have port iREQ_DATA0, input, PL_N bits: unsigned multiplicand.
REQ-008 SHALL have port iREQ_DATA1, input, PL_N bits: unsigned multiplier.
REQ-009 SHALL have port oOUT_VALID, output, 1 bit: a result is present.
REQ-010 SHALL have port iOUT_BUSY, input, 1 bit: the downstream stage stalls the result.
REQ-011 SHALL have port oOUT_DATA, output, 2*PL_N bits: the product.

Function
REQ-012 SHALL compute oOUT_DATA = iREQ_DATA0 * iREQ_DATA1, unsigned and exact, with no truncation.
REQ-013 SHALL use an iterative radix-4 Booth method: the multiplier is zero-extended by 2 bits and given an implicit 0 below bit 0, and one 3-bit group is processed per cycle, LSB group first.
REQ-014 SHALL select the partial product per group as follows: 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X. It SHALL add the selected value, shifted left by 2*i, into a signed accumulator of at least 2*PL_N+3 bits.
REQ-015 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-016 SHALL accept a request on an edge where iREQ_VALID=1 and oREQ_BUSY=0, capturing both operands, clearing the accumulator, zeroing the group counter and entering CALC.
REQ-017 SHALL drive oREQ_BUSY=1 whenever the state is not IDLE; there is no same-cycle accept while a result is being drained.
REQ-018 SHALL stay in CALC for exactly PL_N/2+1 cycles, one group per cycle; the edge that processes the last group enters DONE.
REQ-019 SHALL make oOUT_VALID=1 on the (PL_N/2+1)th rising edge after the accepting edge; for PL_N=24 this is 13 edges.
REQ-020 SHALL hold oOUT_VALID and oOUT_DATA stable in DONE while iOUT_BUSY=1.
REQ-021 SHALL go from DONE to IDLE on an edge where iOUT_BUSY=0; oREQ_BUSY falls on that same edge.
REQ-022 SHALL drive oOUT_VALID=1 only in DONE; oOUT_DATA is don't-care while oOUT_VALID=0 but SHALL NOT contain X.
REQ-023 SHALL, when iFLUSH=1 on an edge and in any state, go to IDLE, clear oOUT_VALID and discard the operation; iFLUSH takes priority over an accept or completion on that same edge.
REQ-024 SHALL treat iREQ_VALID as don't-care while oREQ_BUSY=1; the operands are not re-sampled.

Reset
REQ-025 SHALL on inRESET=0, immediately and regardless of clock, set the state to IDLE, oREQ_BUSY=0, oOUT_VALID=0, oOUT_DATA=0, and the accumulator, operand registers and counter to 0.
REQ-026 SHALL, on reset asserted mid-CALC or in DONE, lose the result; no oOUT_VALID is produced for that operation after reset is released.
REQ-027 SHALL be able to accept a request on the first rising edge after inRESET deasserts.

Configuration
REQ-028 SHALL recognise the macro FMUL_BOOTH_SEQ_ZERO_SKIP_EN.
REQ-029 SHALL, with FMUL_BOOTH_SEQ_ZERO_SKIP_EN defined, bypass CALC when either captured operand is 0: the accepting edge goes straight to DONE with oOUT_DATA=0, so oOUT_VALID=1 one edge after the accept.
REQ-030 SHALL, with FMUL_BOOTH_SEQ_ZERO_SKIP_EN undefined, give zero operands the normal PL_N/2+1 latency; results are identical in both builds.

Verification
REQ-031 SHALL cover: PL_N=24, DATA0=3, DATA1=5, iOUT_BUSY=0 -> oOUT_DATA=0x00000000000F, oOUT_VALID on the 13th edge after accept, high for 1 cycle.
REQ-032 SHALL cover: PL_N=24, DATA0=DATA1=0xFFFFFF -> oOUT_DATA=0xFFFFFE000001, which exercises every -X/-2X group and the final extension group.
REQ-033 SHALL cover: DATA0=0x800000, DATA1=0x000002 with iOUT_BUSY=1 for 5 cycles after oOUT_VALID -> result 0x000001000000 held constant with oREQ_BUSY=1; IDLE on the first edge with iOUT_BUSY=0.
REQ-034 SHALL cover: iFLUSH pulsed in the 6th CALC cycle -> no oOUT_VALID; a new request 7*9 issued next cycle -> 0x3F after 13 edges.
REQ-035 SHALL cover: inRESET asserted mid-CALC, asynchronously between edges -> oREQ_BUSY and oOUT_VALID drop immediately; no stale result after release.
REQ-036 SHALL cover: DATA0=0, DATA1=0x123456 -> 0; oOUT_VALID after 1 edge with FMUL_BOOTH_SEQ_ZERO_SKIP_EN defined, after 13 edges without it.
